rom_frame_scheduler: RTL and testbench

- Sequences ROM reads that fill an 8-digit display frame starting at a base address from the marquee address stepper.
- Holds the frame in a double buffer, so the display never shows a partially loaded frame.
- Time-multiplexes the front buffer onto an 8-digit common-anode display.
- Sits between the speed/pause address controller and the pattern ROM / 7-seg pins.

---
 rtl/rom_frame_scheduler.sv | 176 +++++++++++++++++
 tb/tb_rom_frame_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_frame_scheduler.sv
// Loads an 8-byte display frame from a pattern ROM into a back buffer, swaps it
// to the front buffer atomically, and scans the front buffer onto a common-anode
// display. Optional SCAN_BLANK_EN blanks all digits for the first 16 cycles of each slot.
module rom_frame_scheduler #(
  parameter int ROM_LAT  = 2,
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100_000
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic [7:0] base_addr,
  input  logic       frame_req,
  output logic [7:0] rom_addr,
  output logic       rom_en,
  input  logic [7:0] rom_data,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] digit_sel,
  output logic [7:0] digit_data
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, SWAP} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       issue_cnt_reg;
  logic [7:0]       addr_reg;
  logic             pend_reg;
  logic [7:0]       pend_base_reg;
  logic             accept;
  logic [7:0]       accept_base;
  logic             inflight;

  logic [ROM_LAT-1:0] vld_pipe_reg;
  logic [2:0]         idx_pipe_reg [ROM_LAT];

  logic [7:0]        back_reg  [DIGITS];
  logic [7:0]        front_reg [DIGITS];
  logic [DIGITS-1:0] back_we;

  logic [CNT_W-1:0] scan_cnt_reg;
  logic [2:0]       scan_idx_reg;

  // A fresh request in IDLE wins over the pending base (last request wins).
  assign accept      = (state_reg == IDLE) && (frame_req || pend_reg);
  assign accept_base = frame_req ? base_addr : pend_base_reg;
  assign rom_addr    = addr_reg;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rom_en     = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (frame_req || pend_reg) state_next = ISSUE;
      end
      ISSUE: begin
        rom_en = 1'b1;
        if (issue_cnt_reg == 3'd7) state_next = DRAIN;
      end
      DRAIN: begin
        if (!inflight) state_next = SWAP;
      end
      SWAP: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      issue_cnt_reg <= 3'd0;
      addr_reg      <= 8'h00;
      pend_reg      <= 1'b0;
      pend_base_reg <= 8'h00;
    end else if (accept) begin
      issue_cnt_reg <= 3'd0;
      addr_reg      <= accept_base;
      pend_reg      <= 1'b0;
    end else begin
      if (frame_req) begin
        pend_reg      <= 1'b1;
        pend_base_reg <= base_addr;
      end
      if (state_reg == ISSUE) begin
        issue_cnt_reg <= issue_cnt_reg + 3'd1;
        // Address stops on base+7 so it holds the last issued value afterwards.
        if (issue_cnt_reg != 3'd7) addr_reg <= addr_reg + 8'd1;
      end
    end
  end

  // Delay line tracking outstanding reads; the last stage lines up with rom_data.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      vld_pipe_reg <= '0;
      for (int i = 0; i < ROM_LAT; i++) idx_pipe_reg[i] <= 3'd0;
    end else begin
      vld_pipe_reg[0] <= rom_en;
      idx_pipe_reg[0] <= issue_cnt_reg;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_pipe_reg[i] <= vld_pipe_reg[i-1];
        idx_pipe_reg[i] <= idx_pipe_reg[i-1];
      end
    end
  end

  // The last stage retires this cycle, so only earlier stages hold off the swap.
  generate
    if (ROM_LAT > 1) begin : g_inflight
      assign inflight = |vld_pipe_reg[ROM_LAT-2:0];
    end else begin : g_no_inflight
      assign inflight = 1'b0;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_back_we
      assign back_we[gi] = vld_pipe_reg[ROM_LAT-1] &&
                           (idx_pipe_reg[ROM_LAT-1] == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        back_reg[i]  <= 8'h00;
        front_reg[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (back_we[i]) back_reg[i] <= rom_data;
        if (state_reg == SWAP) front_reg[i] <= back_reg[i];
      end
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      scan_cnt_reg <= '0;
      scan_idx_reg <= 3'd0;
    end else if (scan_cnt_reg == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt_reg <= '0;
      scan_idx_reg <= scan_idx_reg + 3'd1;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    digit_data = front_reg[scan_idx_reg];
    digit_sel  = ~(8'b1 << scan_idx_reg);
`ifdef SCAN_BLANK_EN
    if (scan_cnt_reg < CNT_W'(16)) digit_sel = 8'hFF;
`else
`endif
  end

endmodule

// File: tb/tb_rom_frame_scheduler.sv
// Directed bench for rom_frame_scheduler: reset/scan, frame loads, address wrap,
// back-to-back requests with pending overwrite, and reset in the middle of a load.
module tb_rom_frame_scheduler;

  localparam int SD = 20;
  localparam int RL = 2;

  logic       clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] base_addr = 8'h00;
  logic       frame_req = 1'b0;
  logic [7:0] rom_addr;
  logic       rom_en;
  logic [7:0] rom_data;
  logic       busy;
  logic       frame_done;
  logic [7:0] digit_sel;
  logic [7:0] digit_data;

  int errors = 0;
  int checks = 0;

  logic [7:0] rom_pipe [RL];

  rom_frame_scheduler #(.ROM_LAT(RL), .DIGITS(8), .SCAN_DIV(SD)) dut (
    .clk(clk), .Rst(Rst), .base_addr(base_addr), .frame_req(frame_req),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .busy(busy), .frame_done(frame_done),
    .digit_sel(digit_sel), .digit_data(digit_data)
  );

  always #5 clk = ~clk;

  // ROM model: data = addr ^ 8'h5A, RL cycles after the address.
  always @(posedge clk) begin
    rom_pipe[0] <= rom_addr ^ 8'h5A;
    for (int i = 1; i < RL; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[RL-1];

  // Hand-computed frames, byte i at [8*i +: 8].
  localparam logic [63:0] FRAME_10 = {8'h4D, 8'h4C, 8'h4F, 8'h4E, 8'h49, 8'h48, 8'h4B, 8'h4A};
  localparam logic [63:0] FRAME_FC = {8'h59, 8'h58, 8'h5B, 8'h5A, 8'hA5, 8'hA4, 8'hA7, 8'hA6};
  localparam logic [63:0] FRAME_20 = {8'h7D, 8'h7C, 8'h7F, 8'h7E, 8'h79, 8'h78, 8'h7B, 8'h7A};
  localparam logic [63:0] FRAME_40 = {8'h1D, 8'h1C, 8'h1F, 8'h1E, 8'h19, 8'h18, 8'h1B, 8'h1A};
  localparam logic [63:0] FRAME_00 = 64'h0;

  task automatic test_reset();
    logic [7:0] oh;
    logic [7:0] exp_sel;
    int slot;
    Rst = 1'b1;
    frame_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (digit_sel !== 8'hFE) begin errors++; $display("FAIL reset_sel got=%h exp=fe", digit_sel); end
    checks++; if (digit_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", digit_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en got=%b exp=0", rom_en); end
    checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL reset_rom_addr got=%h exp=00", rom_addr); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    Rst = 1'b0;
    for (int n = 0; n < 9 * SD; n++) begin
      if (n > 0) @(negedge clk);
      slot = (n / SD) % 8;
      oh = 8'b1 << slot;
      exp_sel = ~oh;
`ifdef SCAN_BLANK_EN
      if ((n % SD) < 16) exp_sel = 8'hFF;
`endif
      checks++; if (digit_sel !== exp_sel) begin errors++; $display("FAIL scan_sel n=%0d got=%h exp=%h", n, digit_sel, exp_sel); end
      checks++; if (digit_data !== 8'h00) begin errors++; $display("FAIL scan_data n=%0d got=%h exp=00", n, digit_data); end
      checks++; if (rom_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_quiet n=%0d rom_en=%b busy=%b exp=0,0", n, rom_en, busy); end
    end
    $display("test_reset: scan sequence observed for %0d cycles", 9 * SD);
  endtask

  // Watch a full scan rotation and compare every visible digit to the expected frame.
  task automatic check_frame(input logic [63:0] exp_f, input string name);
    logic [7:0] seen;
    logic [7:0] oh;
    logic [7:0] exp_b;
    int idx;
    seen = 8'h00;
    for (int c = 0; c < 8 * SD; c++) begin
      @(negedge clk);
      if (digit_sel !== 8'hFF) begin
        idx = -1;
        for (int i = 0; i < 8; i++) begin
          oh = 8'b1 << i;
          if (digit_sel === ~oh) idx = i;
        end
        checks++;
        if (idx < 0) begin
          errors++; $display("FAIL %s_sel_onehot got=%h exp=one-hot-low", name, digit_sel);
        end else begin
          exp_b = exp_f[8*idx +: 8];
          seen[idx] = 1'b1;
          if (digit_data !== exp_b) begin
            errors++; $display("FAIL %s_digit%0d got=%h exp=%h", name, idx, digit_data, exp_b);
          end
        end
      end
    end
    checks++; if (seen !== 8'hFF) begin errors++; $display("FAIL %s_coverage got=%h exp=ff", name, seen); end
    $display("check_frame %s: front buffer scanned", name);
  endtask

  task automatic test_load(input logic [7:0] base, input logic [63:0] exp_f, input string name);
    logic [7:0] exp_addr;
    @(negedge clk);
    frame_req = 1'b1;
    base_addr = base;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) frame_req = 1'b0;
      if (k <= 8) begin
        exp_addr = base + 8'(k - 1);
        checks++; if (rom_en !== 1'b1) begin errors++; $display("FAIL %s_rom_en k=%0d got=%b exp=1", name, k, rom_en); end
        checks++; if (rom_addr !== exp_addr) begin errors++; $display("FAIL %s_rom_addr k=%0d got=%h exp=%h", name, k, rom_addr, exp_addr); end
      end else begin
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL %s_rom_en k=%0d got=%b exp=0", name, k, rom_en); end
      end
      checks++; if (frame_done !== (k == 11)) begin errors++; $display("FAIL %s_frame_done k=%0d got=%b exp=%b", name, k, frame_done, k == 11); end
      checks++; if (busy !== (k <= 11)) begin errors++; $display("FAIL %s_busy k=%0d got=%b exp=%b", name, k, busy, k <= 11); end
    end
    $display("test_load %s: base=%h loaded", name, base);
    check_frame(exp_f, name);
  endtask

  task automatic test_back_to_back();
    logic exp_en, exp_done, exp_busy;
    logic [7:0] exp_addr;
    logic [7:0] oh;
    @(negedge clk);
    frame_req = 1'b1;
    base_addr = 8'h20;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      exp_en   = (k >= 1 && k <= 8) || (k >= 13 && k <= 20);
      exp_done = (k == 11) || (k == 23);
      exp_busy = (k >= 1 && k <= 11) || (k >= 13 && k <= 23);
      checks++; if (rom_en !== exp_en) begin errors++; $display("FAIL b2b_rom_en k=%0d got=%b exp=%b", k, rom_en, exp_en); end
      if (exp_en) begin
        exp_addr = (k <= 8) ? 8'h20 + 8'(k - 1) : 8'h40 + 8'(k - 13);
        checks++; if (rom_addr !== exp_addr) begin errors++; $display("FAIL b2b_rom_addr k=%0d got=%h exp=%h", k, rom_addr, exp_addr); end
      end
      checks++; if (frame_done !== exp_done) begin errors++; $display("FAIL b2b_frame_done k=%0d got=%b exp=%b", k, frame_done, exp_done); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, busy, exp_busy); end
      if (k == 12 && digit_sel !== 8'hFF) begin
        for (int i = 0; i < 8; i++) begin
          oh = 8'b1 << i;
          if (digit_sel === ~oh) begin
            checks++;
            if (digit_data !== FRAME_20[8*i +: 8]) begin
              errors++; $display("FAIL b2b_first_frame digit%0d got=%h exp=%h", i, digit_data, FRAME_20[8*i +: 8]);
            end
          end
        end
      end
      case (k)
        1: frame_req = 1'b0;
        3: begin frame_req = 1'b1; base_addr = 8'h30; end
        4: frame_req = 1'b0;
        5: begin frame_req = 1'b1; base_addr = 8'h40; end
        6: frame_req = 1'b0;
        default: ;
      endcase
    end
    $display("test_back_to_back: bases 20 then 40 loaded");
    check_frame(FRAME_40, "b2b_second");
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    frame_req = 1'b1;
    base_addr = 8'h50;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) frame_req = 1'b0;
    end
    checks++; if (rom_en !== 1'b1) begin errors++; $display("FAIL midrst_pre_rom_en got=%b exp=1", rom_en); end
    Rst = 1'b1;
    #1;
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL midrst_rom_en got=%b exp=0", rom_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL midrst_rom_addr got=%h exp=00", rom_addr); end
    repeat (2) @(negedge clk);
    Rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++; if (frame_done !== 1'b0 || rom_en !== 1'b0) begin errors++; $display("FAIL midrst_quiet k=%0d frame_done=%b rom_en=%b exp=0,0", k, frame_done, rom_en); end
    end
    $display("test_reset_mid_load: load aborted");
    check_frame(FRAME_00, "midrst_cleared");
    test_load(8'h10, FRAME_10, "after_rst");
  endtask

  initial begin
    test_reset();
    test_load(8'h10, FRAME_10, "base10");
    test_load(8'hFC, FRAME_FC, "baseFC");
    test_back_to_back();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
